// File: rtl/cam_downscale.sv
// cam_downscale: 2x2 box-filter downscaler for a raster pixel stream.
// Each 2x2 input block produces one output pixel that is the mean of its four pixels.
// Position is taken only from the incoming hcount/vcount. The block has no free-running counters.
//
// Parameters: IMG_WIDTH, IMG_HEIGHT (both even), DATA_WIDTH.
// Ports:
//   clk, rst            - clock; asynchronous active-high reset
//   in_valid            - din/hcount/vcount accepted this cycle
//   hcount, vcount      - input pixel column / line
//   din                 - input pixel
//   out_valid           - 1-cycle pulse qualifying dout/out_hcount/out_vcount
//   out_hcount/vcount   - output column / line (input position >> 1)
//   dout                - averaged 2x2 pixel
// Build option: define CAM_DOWNSCALE_ROUND_EN to round the mean to nearest.
//   The default build truncates the mean.
module cam_downscale #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [$clog2(IMG_WIDTH)-1:0]      hcount,
  input  logic [$clog2(IMG_HEIGHT)-1:0]     vcount,
  input  logic [DATA_WIDTH-1:0]             din,
  output logic                              out_valid,
  output logic [$clog2(IMG_WIDTH/2)-1:0]    out_hcount,
  output logic [$clog2(IMG_HEIGHT/2)-1:0]   out_vcount,
  output logic [DATA_WIDTH-1:0]             dout
);

  localparam int HW  = $clog2(IMG_WIDTH);
  localparam int VW  = $clog2(IMG_HEIGHT);
  localparam int OHW = $clog2(IMG_WIDTH/2);
  localparam int OVW = $clog2(IMG_HEIGHT/2);
  localparam int LW  = DATA_WIDTH + 1;
  localparam int SW  = DATA_WIDTH + 2;

  // Horizontal pair sums of the previous even line. This buffer is not reset.
  // Stale entries cannot reach the output because the primed flag gates the output.
  logic [LW-1:0]          r_lbuf [IMG_WIDTH/2];

  logic [DATA_WIDTH-1:0]  r_pair;
  logic                   r_primed;
  logic                   r_out_valid;
  logic [OHW-1:0]         r_out_hcount;
  logic [OVW-1:0]         r_out_vcount;
  logic [DATA_WIDTH-1:0]  r_dout;

  logic [OHW-1:0]         w_col;
  logic                   w_odd_line;
  logic                   w_odd_col;
  logic                   w_first_col;
  logic                   w_last_col;
  logic [LW-1:0]          w_pair_sum;
  logic [SW-1:0]          w_sum;
  logic [SW-1:0]          w_adj;
  logic [DATA_WIDTH-1:0]  w_avg;

  assign w_col       = hcount[HW-1:1];
  assign w_odd_line  = vcount[0];
  assign w_odd_col   = hcount[0];
  assign w_first_col = (hcount == '0);
  assign w_last_col  = (hcount == HW'(IMG_WIDTH - 1));

  assign w_pair_sum  = LW'(r_pair) + LW'(din);
  assign w_sum       = SW'(r_lbuf[w_col]) + SW'(r_pair) + SW'(din);

`ifdef CAM_DOWNSCALE_ROUND_EN
  // The maximum sum is 4*(2^DW-1), so adding 2 still fits in SW bits.
  assign w_adj = w_sum + SW'(2);
`else
  assign w_adj = w_sum;
`endif

  assign w_avg = DATA_WIDTH'(w_adj >> 2);

  always_ff @(posedge clk) begin
    if (in_valid && !w_odd_line && w_odd_col) begin
      r_lbuf[w_col] <= w_pair_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pair       <= '0;
      r_primed     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_hcount <= '0;
      r_out_vcount <= '0;
      r_dout       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (in_valid) begin
        if (!w_odd_col) begin
          r_pair <= din;
        end
        if (!w_odd_line) begin
          if (w_first_col) begin
            r_primed <= 1'b1;
          end
        end else begin
          if (w_odd_col && r_primed) begin
            r_out_valid  <= 1'b1;
            r_dout       <= w_avg;
            r_out_hcount <= w_col;
            r_out_vcount <= vcount[VW-1:1];
          end
          // The last pixel of an odd line still uses the primed value from before this clear.
          if (w_last_col) begin
            r_primed <= 1'b0;
          end
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_hcount = r_out_hcount;
  assign out_vcount = r_out_vcount;
  assign dout       = r_dout;

endmodule

// File: tb/tb_cam_downscale.sv
module tb_cam_downscale;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int BW  = 640;
  localparam int BH  = 480;
  localparam int SHW = $clog2(W);
  localparam int SVW = $clog2(H);
  localparam int BHW = $clog2(BW);
  localparam int BVW = $clog2(BH);

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic           s_iv, s_ov;
  logic [SHW-1:0] s_h;
  logic [SVW-1:0] s_v;
  logic [7:0]     s_d, s_do;
  logic [$clog2(W/2)-1:0] s_oh;
  logic [$clog2(H/2)-1:0] s_ovc;

  logic           b_iv, b_ov;
  logic [BHW-1:0] b_h;
  logic [BVW-1:0] b_v;
  logic [7:0]     b_d, b_do;
  logic [$clog2(BW/2)-1:0] b_oh;
  logic [$clog2(BH/2)-1:0] b_ovc;

  cam_downscale #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_iv), .hcount(s_h), .vcount(s_v), .din(s_d),
    .out_valid(s_ov), .out_hcount(s_oh), .out_vcount(s_ovc), .dout(s_do));

  cam_downscale #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH), .DATA_WIDTH(8)) u_big (
    .clk(clk), .rst(rst), .in_valid(b_iv), .hcount(b_h), .vcount(b_v), .din(b_d),
    .out_valid(b_ov), .out_hcount(b_oh), .out_vcount(b_ovc), .dout(b_do));

  typedef struct { int d; int oh; int ov; int due; } exp_t;
  typedef struct { logic [31:0] px; logic [7:0] et; logic [7:0] er; } vec_t;

  exp_t sq[$];
  exp_t bq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   s_seen = 0;
  int   b_seen = 0;
  bit   s_mon = 1'b0;
  bit   m_primed = 1'b0;
  bit   b_primed = 1'b0;
  int   img [H][W];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int avg4(input int a, input int b, input int c, input int e);
    int s;
    s = a + b + c + e;
`ifdef CAM_DOWNSCALE_ROUND_EN
    return (s + 2) / 4;
`else
    return s / 4;
`endif
  endfunction

  // Quadrant test image used for the 640x480 instance.
  function automatic int quad(input int x, input int y);
    if (y < BH / 2) return (x < BW / 2) ? 'h00 : 'h40;
    else            return (x < BW / 2) ? 'h80 : 'hFF;
  endfunction

  always @(posedge clk) cyc++;

  // Small-instance scoreboard
  always @(posedge clk) begin
    #2;
    if (s_mon) begin
      while (sq.size() > 0 && sq[0].due < cyc) begin
        n_cmp++; n_err++;
        $display("FAIL s_missing: out_valid=0 at cycle %0d, required 1 for (%0d,%0d)", sq[0].due, sq[0].oh, sq[0].ov);
        sq.delete(0);
      end
      if (s_ov) begin
        s_seen++;
        if (sq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL s_extra: got out_valid=1 at (%0d,%0d) cycle %0d, required 0", s_oh, s_ovc, cyc);
        end else begin
          check("s_dout", int'(s_do), sq[0].d);
          check("s_out_hcount", int'(s_oh), sq[0].oh);
          check("s_out_vcount", int'(s_ovc), sq[0].ov);
          check("s_latency", cyc, sq[0].due);
          sq.delete(0);
        end
      end
    end
  end

  // Large-instance scoreboard
  always @(posedge clk) begin
    #2;
    while (bq.size() > 0 && bq[0].due < cyc) begin
      n_cmp++; n_err++;
      $display("FAIL b_missing: out_valid=0 at cycle %0d, required 1 for (%0d,%0d)", bq[0].due, bq[0].oh, bq[0].ov);
      bq.delete(0);
    end
    if (b_ov) begin
      b_seen++;
      if (bq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b_extra: got out_valid=1 at (%0d,%0d), required 0", b_oh, b_ovc);
      end else begin
        check("b_dout", int'(b_do), bq[0].d);
        check("b_out_hcount", int'(b_oh), bq[0].oh);
        check("b_out_vcount", int'(b_ovc), bq[0].ov);
        check("b_latency", cyc, bq[0].due);
        bq.delete(0);
      end
    end
  end

  task automatic spix(input int x, input int y, input int d);
    @(negedge clk);
    s_iv = 1'b1; s_h = SHW'(x); s_v = SVW'(y); s_d = 8'(d);
    img[y][x] = d;
    if (y % 2 == 0 && x == 0) m_primed = 1'b1;
    if (y % 2 == 1 && x % 2 == 1 && m_primed)
      sq.push_back('{avg4(img[y-1][x-1], img[y-1][x], img[y][x-1], d), x / 2, y / 2, cyc + 1});
    if (y % 2 == 1 && x == W - 1) m_primed = 1'b0;
  endtask

  task automatic sidle();
    @(negedge clk);
    s_iv = 1'b0; s_h = SHW'($urandom); s_v = SVW'($urandom); s_d = 8'($urandom);
  endtask

  task automatic sframe(input int rnd, input int gap);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        spix(x, y, rnd != 0 ? int'($urandom_range(0, 255)) : 'h40);
        if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) sidle();
      end
  endtask

  task automatic bpix(input int x, input int y);
    int d;
    d = quad(x, y);
    @(negedge clk);
    b_iv = 1'b1; b_h = BHW'(x); b_v = BVW'(y); b_d = 8'(d);
    if (y % 2 == 0 && x == 0) b_primed = 1'b1;
    if (y % 2 == 1 && x % 2 == 1 && b_primed)
      bq.push_back('{avg4(quad(x-1, y-1), quad(x, y-1), quad(x-1, y), d), x / 2, y / 2, cyc + 1});
    if (y % 2 == 1 && x == BW - 1) b_primed = 1'b0;
  endtask

  task automatic check_reset_small(input string tag);
    check({tag, "_out_valid"}, int'(s_ov), 0);
    check({tag, "_dout"}, int'(s_do), 0);
    check({tag, "_out_hcount"}, int'(s_oh), 0);
    check({tag, "_out_vcount"}, int'(s_ovc), 0);
  endtask

  vec_t tv [6];
  int   lines [12] = '{0, 1, 236, 237, 238, 239, 240, 241, 242, 243, 478, 479};

  initial begin
    tv[0] = '{32'h01010100, 8'h00, 8'h01};
    tv[1] = '{32'hFFFFFFFF, 8'hFF, 8'hFF};
    tv[2] = '{32'h00000000, 8'h00, 8'h00};
    tv[3] = '{32'hFFFFFFFE, 8'hFE, 8'hFF};
    tv[4] = '{32'h01020304, 8'h02, 8'h03};
    tv[5] = '{32'h00000002, 8'h00, 8'h01};

    rst = 1'b1;
    s_iv = 1'b0; s_h = '0; s_v = '0; s_d = '0;
    b_iv = 1'b0; b_h = '0; b_v = '0; b_d = '0;
    repeat (2) @(negedge clk);
    check_reset_small("rst_init");
    check("rst_init_big_valid", int'(b_ov), 0);
    check("rst_init_big_dout", int'(b_do), 0);
    rst = 1'b0;

    // Single 2x2 blocks from the vector table, checked directly
    for (int i = 0; i < 6; i++) begin
      logic [31:0] px;
      int exp;
      px = tv[i].px;
`ifdef CAM_DOWNSCALE_ROUND_EN
      exp = int'(tv[i].er);
`else
      exp = int'(tv[i].et);
`endif
      spix(0, 0, int'(px[31:24]));
      spix(1, 0, int'(px[23:16]));
      spix(0, 1, int'(px[15:8]));
      spix(1, 1, int'(px[7:0]));
      @(negedge clk); s_iv = 1'b0;
      check("tab_valid", int'(s_ov), 1);
      check("tab_dout", int'(s_do), exp);
      @(negedge clk);
      check("tab_pulse", int'(s_ov), 0);
    end
    sq.delete();
    s_mon = 1'b1;

    // Flat 0x40 frame from a free-running source
    s_seen = 0;
    sframe(0, 0); sidle(); sidle();
    check("flat_count", s_seen, 8);
    check("flat_pending", sq.size(), 0);

    // Same frame, in_valid toggling every other cycle
    s_seen = 0;
    sframe(0, 1); sidle(); sidle();
    check("gap_count", s_seen, 8);
    check("gap_pending", sq.size(), 0);

    // Two back-to-back random frames: output (3,1) must be followed directly by (0,0)
    s_seen = 0;
    sframe(1, 0); sframe(1, 0); sidle(); sidle();
    check("b2b_count", s_seen, 16);
    check("b2b_pending", sq.size(), 0);

    // Random data with random stalls
    s_seen = 0;
    for (int f = 0; f < 3; f++) sframe(1, 2);
    sidle(); sidle();
    check("rand_count", s_seen, 24);
    check("rand_pending", sq.size(), 0);

    // An odd line with no even line before it produces no output
    s_seen = 0;
    for (int x = 0; x < W; x++) spix(x, 1, int'($urandom_range(0, 255)));
    sidle(); sidle();
    check("orphan_count", s_seen, 0);

    // Mid-frame reset at line 1, hcount 3
    s_seen = 0;
    for (int x = 0; x < W; x++) spix(x, 0, 'h40);
    for (int x = 0; x < 3; x++) spix(x, 1, 'h40);
    @(negedge clk);
    rst = 1'b1; s_iv = 1'b1; s_h = SHW'(3); s_v = SVW'(1); s_d = 8'h40;
    m_primed = 1'b0; b_primed = 1'b0;
    #1;
    check_reset_small("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    for (int x = 4; x < W; x++) spix(x, 1, 'h40);
    for (int y = 2; y < H; y++)
      for (int x = 0; x < W; x++) spix(x, y, 'h40);
    sidle(); sidle();
    check("rst_mid_count", s_seen, 5);
    check("rst_mid_pending", sq.size(), 0);

    // 640x480 quadrant image, driven on the line pairs around the split and at the frame edges
    b_seen = 0;
    for (int i = 0; i < 12; i++)
      for (int x = 0; x < BW; x++) bpix(x, lines[i]);
    @(negedge clk); b_iv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("quad_count", b_seen, 6 * (BW / 2));
    check("quad_pending", bq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
